// File: rtl/alk_pkg.sv
// Shared encodings for the ALK Q-register slice: Q operations, shift-in
// sources and multiply/divide loop modes.
package alk_pkg;

    typedef enum logic [2:0] {
        QOP_HOLD = 3'd0,
        QOP_LOAD = 3'd1,
        QOP_SL   = 3'd2,
        QOP_SR   = 3'd3,
        QOP_ROL  = 3'd4,
        QOP_ROR  = 3'd5
    } qop_e;

    typedef enum logic [2:0] {
        QSI_ZERO = 3'd0,
        QSI_ONE  = 3'd1,
        QSI_SHL  = 3'd2,
        QSI_SHR  = 3'd3,
        QSI_C32  = 3'd4,
        QSI_PSLC = 3'd5,
        QSI_WB31 = 3'd6,
        QSI_WB30 = 3'd7
    } qsi_e;

    typedef enum logic [1:0] {
        LOOP_NONE = 2'd0,
        LOOP_MUL  = 2'd1,
        LOOP_DIV  = 2'd2
    } loop_mode_e;

    // Number of shift-in sources the QSI encoding covers.
    localparam int QSI_COUNT = 8;

endpackage

// File: rtl/alk_loop_ctr.sv
// Multiply/divide step counter: produces LOOPF (counter nonzero) and a
// one-cycle done pulse after the counter reaches zero.
module alk_loop_ctr #(
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             rst_l,
    input  logic             loop_start_h,
    input  logic [CNT_W-1:0] loop_cnt_h,
    input  logic             step_h,
    output logic             loopf_h,
    output logic             loop_done_h
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loopf_q, loopf_d;
    logic             done_q, done_d;

    // A start always wins over a step and restarts the loop; a zero count
    // is a zero-iteration loop that still reports done.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (loop_start_h) begin
            cnt_d  = loop_cnt_h;
            done_d = (loop_cnt_h == '0);
        end else if (step_h && (cnt_q != '0)) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
        loopf_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_h or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q   <= '0;
            loopf_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            loopf_q <= loopf_d;
            done_q  <= done_d;
        end
    end

    assign loopf_h     = loopf_q;
    assign loop_done_h = done_q;

endmodule

// File: rtl/alk_qshift_seq.sv
// ALK Q-register slice: Q register with load/shift/rotate, generalised
// shift-in source selection and a multiply/divide step loop.
module alk_qshift_seq
    import alk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6,
    parameter int NSRC  = 8
) (
    input  logic             clk_h,
    input  logic             rst_l,
    input  logic [2:0]       q_op_h,
    input  logic [2:0]       sin_sel_h,
    input  logic [WIDTH-1:0] wb_in_h,
    input  logic             alu_sout_shl_h,
    input  logic             alu_sout_shr_h,
    input  logic             c32_in_h,
    input  logic             pslc_h,
    input  logic [1:0]       loop_mode_h,
    input  logic             loop_start_h,
    input  logic [CNT_W-1:0] loop_cnt_h,
    input  logic             step_h,
    output logic [WIDTH-1:0] q_h,
    output logic             q_sout_shl_h,
    output logic             q_sout_shr_h,
    output logic             q_sin_h,
    output logic             loopf_h,
    output logic             loop_done_h
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [NSRC-1:0]  sin_src;
    logic             sel_bit;
    logic             sin;
    logic             mul_step, div_step;

    always_comb begin
        sin_src           = '0;
        sin_src[QSI_ZERO] = 1'b0;
        sin_src[QSI_ONE]  = 1'b1;
        sin_src[QSI_SHL]  = alu_sout_shl_h;
        sin_src[QSI_SHR]  = alu_sout_shr_h;
        sin_src[QSI_C32]  = c32_in_h;
        sin_src[QSI_PSLC] = pslc_h;
        sin_src[QSI_WB31] = wb_in_h[WIDTH-1];
        sin_src[QSI_WB30] = wb_in_h[WIDTH-2];
        sel_bit           = sin_src[sin_sel_h];
    end

    // Loop mode is sampled live each cycle; an active loop step overrides q_op_h.
    assign mul_step = loopf_h && step_h && (loop_mode_h == LOOP_MUL);
    assign div_step = loopf_h && step_h && (loop_mode_h == LOOP_DIV);

    always_comb begin
        q_d = q_q;
        sin = 1'b0;
        if (mul_step) begin
            sin = alu_sout_shr_h;
            q_d = {sin, q_q[WIDTH-1:1]};
        end else if (div_step) begin
            sin = c32_in_h;
            q_d = {q_q[WIDTH-2:0], sin};
        end else begin
            case (q_op_h)
                QOP_LOAD: q_d = wb_in_h;
                QOP_SL: begin
                    sin = sel_bit;
                    q_d = {q_q[WIDTH-2:0], sin};
                end
                QOP_SR: begin
                    sin = sel_bit;
                    q_d = {sin, q_q[WIDTH-1:1]};
                end
                QOP_ROL: begin
                    sin = q_q[WIDTH-1];
                    q_d = {q_q[WIDTH-2:0], sin};
                end
                QOP_ROR: begin
                    sin = q_q[0];
                    q_d = {sin, q_q[WIDTH-1:1]};
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_h or negedge rst_l) begin
        if (!rst_l) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    alk_loop_ctr #(
        .CNT_W(CNT_W)
    ) u_loop_ctr (
        .clk_h       (clk_h),
        .rst_l       (rst_l),
        .loop_start_h(loop_start_h),
        .loop_cnt_h  (loop_cnt_h),
        .step_h      (step_h),
        .loopf_h     (loopf_h),
        .loop_done_h (loop_done_h)
    );

    assign q_h          = q_q;
    assign q_sout_shl_h = q_q[WIDTH-1];
    assign q_sout_shr_h = q_q[0];
    assign q_sin_h      = sin;

endmodule

// File: doc/alk_qshift_seq.md
Name: alk_qshift_seq

Overview:
Parameterised Q-register datapath slice for the ALK (ALU Control) chip. It holds the Q register, selects the Q shift-in bit from a generalised source set, and executes shifts and rotates. It also runs a multiply/divide step loop counter that generates LOOPF and a loop-done pulse. It sits between the ALK field decoders and the Q shifter routing, so microcode can run WIDTH-bit multiply/divide iterations without per-step shift-in decoding.

Parameters:
WIDTH, 32, Q register width in bits (min 4).
CNT_W, 6, loop counter width; maximum iteration count is 2**CNT_W-1.
NSRC, 8, number of shift-in sources (fixed encoding below; must be 8).

Ports:
clk_h  in  1  system clock, rising edge.
rst_l  in  1  asynchronous reset, active low.
q_op_h  in  3  0 hold, 1 load, 2 SL, 3 SR, 4 rotate L, 5 rotate R, 6-7 hold.
sin_sel_h  in  3  shift-in source for SL/SR: 0 const 0, 1 const 1, 2 alu_sout_shl_h, 3 alu_sout_shr_h, 4 c32_in_h, 5 pslc_h, 6 wb_in_h[WIDTH-1], 7 wb_in_h[WIDTH-2].
wb_in_h  in  WIDTH  WBUS load data.
alu_sout_shl_h  in  1  ALU shift-out, left.
alu_sout_shr_h  in  1  ALU shift-out, right.
c32_in_h  in  1  ALU carry out of MSB.
pslc_h  in  1  PSL.C.
loop_mode_h  in  2  0 none, 1 multiply, 2 divide, 3 reserved (treated as none).
loop_start_h  in  1  load the loop counter.
loop_cnt_h  in  CNT_W  iteration count.
step_h  in  1  execute one loop step.
q_h  out  WIDTH  Q register contents.
q_sout_shl_h  out  1  Q[WIDTH-1], combinational.
q_sout_shr_h  out  1  Q[0], combinational.
q_sin_h  out  1  effective shift-in bit this cycle, combinational.
loopf_h  out  1  loop active (counter nonzero), registered.
loop_done_h  out  1  one-cycle pulse after the final step, registered.

Behaviour:
- Reset (rst_l low, asynchronous): Q=0, counter=0, loopf_h=0, loop_done_h=0. Outputs derived from Q follow, so q_sout_*=0.
- A reset asserted mid-loop aborts the loop. No done pulse is produced.
- Q update priority per rising edge:
  - If loopf_h=1, step_h=1 and loop mode is multiply: Q <= {q_sin_h, Q[WIDTH-1:1]} with q_sin_h=alu_sout_shr_h. q_op_h is ignored.
  - Else if loopf_h=1, step_h=1 and loop mode is divide: Q <= {Q[WIDTH-2:0], q_sin_h} with q_sin_h=c32_in_h. q_op_h is ignored.
  - Else q_op_h applies:
    - load: Q <= wb_in_h.
    - SL: Q <= {Q[WIDTH-2:0], sel}.
    - SR: Q <= {sel, Q[WIDTH-1:1]}.
    - Rotate L: sin = Q[WIDTH-1]. Rotate R: sin = Q[0]. sin_sel_h is ignored for rotates.
- q_sin_h reports the bit actually shifted in this cycle. It is 0 for hold and load.
- Loop counter:
  - loop_start_h=1: counter <= loop_cnt_h. This has priority over step_h in the same cycle and restarts any active loop.
  - Else if step_h=1 and counter!=0: counter decrements.
  - step_h with counter=0 has no effect on the counter. Q still follows q_op_h.
- loopf_h is registered and equals (counter!=0), visible the cycle after the load.
- loop_done_h pulses for exactly one cycle in the cycle after the counter transitions 1->0.
- loop_start_h with loop_cnt_h=0: loopf_h stays 0 and loop_done_h pulses on the next cycle. This is a zero-iteration loop.
- Loop mode is sampled every cycle, not latched. Changing it mid-loop takes effect immediately.
- Latency: Q, loopf_h and loop_done_h update 1 cycle after their inputs. The q_sout_* and q_sin_h outputs are combinational from the current Q and inputs.
- No wrap-around: the counter never decrements below 0.

Decomposition:
- Shared package alk_pkg holds:
  - q_op_h encodings (QOP_HOLD, QOP_LOAD, QOP_SL, QOP_SR, QOP_ROL, QOP_ROR);
  - sin_sel_h encodings (QSI_ZERO … QSI_WB30);
  - loop_mode_h encodings (LOOP_NONE, LOOP_MUL, LOOP_DIV).
- One sub-module, alk_loop_ctr: the counter, loopf_h and loop_done_h generation, parameterised by CNT_W.
- The shift-in mux and the Q register stay in the top level.

Test Plan:
1. Reset is asserted asynchronously mid-cycle during a 5-step loop → q_h=0, loopf_h=0 immediately, and no loop_done_h pulse follows.
2. Load 0x80000001, then SR with sin_sel=1 → q_h=0xC0000000 and q_sin_h=1. Then rotate L → q_h=0x80000001.
3. Load 0x00000003, loop_start with count 4 and multiply mode, step held high, alu_sout_shr_h=1 → loopf_h high for 4 cycles, Q=0xF0000000, loop_done_h pulses once on the 5th cycle.
4. Divide mode, count 2, Q=0x40000000, c32_in_h=1 then 0 → Q=0x00000002 after the two steps, then loop_done_h pulses.
5. loop_start with count 0 → loopf_h stays 0 and loop_done_h=1 for exactly one cycle. loop_start and step_h asserted together with count 3 → counter=3 (step ignored).
6. step_h with counter=0 and q_op=SL, sin_sel=6, wb_in_h[31]=1 → Q shifts left with LSB=1 and the counter stays 0.
